// File: rtl/ram_sp_be_wbuf_pkg.sv
// ram_sp_be_wbuf_pkg
//   Shared constants and helpers for the byte-lane single-port RAM subsystem.
//   - DEF_*_WD : default address/data/column widths.
//   - col_num  : number of columns in a word.
//   - col_merge: per-column select between a new and an old word. It works on
//     MAX_DAT_WD-wide operands, so callers zero-extend their inputs and
//     truncate the result with size casts. This keeps one function usable
//     at any DAT_WD/COL_WD up to MAX_DAT_WD.
package ram_sp_be_wbuf_pkg;

    localparam int DEF_ADR_WD  = 10;
    localparam int DEF_DAT_WD  = 32;
    localparam int DEF_COL_WD  = 8;

    localparam int MAX_DAT_WD  = 1024;
    localparam int MAX_COL_NUM = 1024;
    localparam int MAX_IDX_WD  = 10;

    function automatic int col_num(input int dat_wd, input int col_wd);
        return dat_wd / col_wd;
    endfunction

    // Bit i of the result comes from new_dat when the column holding bit i
    // is enabled in mask, otherwise from old_dat.
    function automatic logic [MAX_DAT_WD-1:0] col_merge(
        input logic [MAX_COL_NUM-1:0] mask,
        input logic [MAX_DAT_WD-1:0]  new_dat,
        input logic [MAX_DAT_WD-1:0]  old_dat,
        input int                     col_wd
    );
        logic [MAX_DAT_WD-1:0] res;
        res = old_dat;
        for (int i = 0; i < MAX_DAT_WD; i++) begin
            if (mask[MAX_IDX_WD'(i / col_wd)]) begin
                res[MAX_IDX_WD'(i)] = new_dat[MAX_IDX_WD'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sp_be_core.sv
// ram_sp_be_core
//   Behavioural single-port RAM with per-column write enables; the only block
//   replaced by a vendor macro at implementation. No reset, contents and read
//   register power up undefined. One access per cycle: the caller never
//   asserts wr_ena and rd_ena together.
//   Ports:
//     clk     : clock, rising edge
//     adr     : shared read/write address
//     wr_ena  : write the columns selected by wr_col with wr_dat
//     wr_col  : per-column write enable
//     wr_dat  : write data
//     rd_ena  : read adr; rd_dat updates on the next edge
//     rd_dat  : read data, changes only after a read
module ram_sp_be_core
    import ram_sp_be_wbuf_pkg::*;
#(
    parameter  int ADR_WD  = DEF_ADR_WD,
    parameter  int DAT_WD  = DEF_DAT_WD,
    parameter  int COL_WD  = DEF_COL_WD,
    localparam int COL_NUM = col_num(DAT_WD, COL_WD)
) (
    input  logic               clk,
    input  logic [ADR_WD-1:0]  adr,
    input  logic               wr_ena,
    input  logic [COL_NUM-1:0] wr_col,
    input  logic [DAT_WD-1:0]  wr_dat,
    input  logic               rd_ena,
    output logic [DAT_WD-1:0]  rd_dat
);

    localparam int DEPTH = 1 << ADR_WD;

    logic [DAT_WD-1:0] mem_q [0:DEPTH-1];
    logic [DAT_WD-1:0] wr_word_d;
    logic [DAT_WD-1:0] rd_dat_d;
    logic [DAT_WD-1:0] rd_dat_q;

    always_comb begin
        wr_word_d = DAT_WD'(col_merge(MAX_COL_NUM'(wr_col),
                                      MAX_DAT_WD'(wr_dat),
                                      MAX_DAT_WD'(mem_q[adr]),
                                      COL_WD));
        rd_dat_d  = rd_ena ? mem_q[adr] : rd_dat_q;
    end

    always_ff @(posedge clk) begin
        if (wr_ena) begin
            mem_q[adr] <= wr_word_d;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/ram_sp_be_wbuf.sv
// ram_sp_be_wbuf
//   Single-port RAM with column write enables and a one-entry write buffer so
//   that a read and a write can be requested in the same cycle. Reads always
//   win the array; a colliding write is parked and drained in the next
//   read-free cycle. Reads hitting the parked entry are forwarded per column.
//   Ports:
//     clk, rstn : clock (rising edge), asynchronous active-low reset
//     wr_ena_i  : write request; accepted when wr_ena_i & wr_rdy_o
//     wr_adr_i  : write address
//     wr_col_i  : per-column write enable (all zero = no-op write)
//     wr_dat_i  : write data
//     wr_rdy_o  : low only while a read meets a full buffer
//     rd_ena_i  : read request, always accepted
//     rd_adr_i  : read address
//     rd_val_o  : one-cycle pulse, the cycle after each read request
//     rd_dat_o  : read data, held until the next rd_val_o, zero after reset
//     idle_o    : write buffer empty
module ram_sp_be_wbuf
    import ram_sp_be_wbuf_pkg::*;
#(
    parameter  int ADR_WD  = DEF_ADR_WD,
    parameter  int DAT_WD  = DEF_DAT_WD,
    parameter  int COL_WD  = DEF_COL_WD,
    localparam int COL_NUM = col_num(DAT_WD, COL_WD)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_ena_i,
    input  logic [ADR_WD-1:0]  wr_adr_i,
    input  logic [COL_NUM-1:0] wr_col_i,
    input  logic [DAT_WD-1:0]  wr_dat_i,
    output logic               wr_rdy_o,
    input  logic               rd_ena_i,
    input  logic [ADR_WD-1:0]  rd_adr_i,
    output logic               rd_val_o,
    output logic [DAT_WD-1:0]  rd_dat_o,
    output logic               idle_o
);

    // Control state (reset)
    logic               wb_vld_q,  wb_vld_d;
    logic               rd_val_q,  rd_val_d;
    logic               rd_seen_q, rd_seen_d;

    // Data state (not reset; qualified by the control bits above)
    logic [ADR_WD-1:0]  wb_adr_q,  wb_adr_d;
    logic [COL_NUM-1:0] wb_col_q,  wb_col_d;
    logic [DAT_WD-1:0]  wb_dat_q,  wb_dat_d;
    logic [COL_NUM-1:0] fwd_col_q, fwd_col_d;
    logic [DAT_WD-1:0]  fwd_dat_q, fwd_dat_d;

    // Array request
    logic               arr_rd_ena;
    logic               arr_wr_ena;
    logic [ADR_WD-1:0]  arr_adr;
    logic [COL_NUM-1:0] arr_wr_col;
    logic [DAT_WD-1:0]  arr_wr_dat;
    logic [DAT_WD-1:0]  arr_rd_dat;

    logic               wr_acc;

    always_comb begin
        wr_rdy_o   = !(wb_vld_q && rd_ena_i);
        wr_acc     = wr_ena_i && wr_rdy_o;

        wb_vld_d   = wb_vld_q;
        wb_adr_d   = wb_adr_q;
        wb_col_d   = wb_col_q;
        wb_dat_d   = wb_dat_q;
        fwd_col_d  = fwd_col_q;
        fwd_dat_d  = fwd_dat_q;
        rd_val_d   = rd_ena_i;
        // Set at issue so the flag is already up in the rd_val_o cycle.
        rd_seen_d  = rd_seen_q || rd_ena_i;

        arr_rd_ena = 1'b0;
        arr_wr_ena = 1'b0;
        arr_adr    = rd_adr_i;
        arr_wr_col = wb_col_q;
        arr_wr_dat = wb_dat_q;

        if (rd_ena_i) begin
            // Read owns the array; a new write can only be accepted here when
            // the buffer is empty, so it parks.
            arr_rd_ena = 1'b1;
            arr_adr    = rd_adr_i;
            if (wb_vld_q && (wb_adr_q == rd_adr_i)) begin
                fwd_col_d = wb_col_q;
            end else begin
                fwd_col_d = '0;
            end
            fwd_dat_d = wb_dat_q;
            if (wr_acc) begin
                wb_vld_d = 1'b1;
                wb_adr_d = wr_adr_i;
                wb_col_d = wr_col_i;
                wb_dat_d = wr_dat_i;
            end
        end else if (wb_vld_q) begin
            // Drain the parked write; a new write takes its slot at once.
            arr_wr_ena = 1'b1;
            arr_adr    = wb_adr_q;
            arr_wr_col = wb_col_q;
            arr_wr_dat = wb_dat_q;
            if (wr_acc) begin
                wb_adr_d = wr_adr_i;
                wb_col_d = wr_col_i;
                wb_dat_d = wr_dat_i;
            end else begin
                wb_vld_d = 1'b0;
            end
        end else if (wr_acc) begin
            arr_wr_ena = 1'b1;
            arr_adr    = wr_adr_i;
            arr_wr_col = wr_col_i;
            arr_wr_dat = wr_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_vld_q  <= 1'b0;
            rd_val_q  <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            wb_vld_q  <= wb_vld_d;
            rd_val_q  <= rd_val_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        wb_adr_q  <= wb_adr_d;
        wb_col_q  <= wb_col_d;
        wb_dat_q  <= wb_dat_d;
        fwd_col_q <= fwd_col_d;
        fwd_dat_q <= fwd_dat_d;
    end

    ram_sp_be_core #(
        .ADR_WD (ADR_WD),
        .DAT_WD (DAT_WD),
        .COL_WD (COL_WD)
    ) u_core (
        .clk    (clk),
        .adr    (arr_adr),
        .wr_ena (arr_wr_ena),
        .wr_col (arr_wr_col),
        .wr_dat (arr_wr_dat),
        .rd_ena (arr_rd_ena),
        .rd_dat (arr_rd_dat)
    );

    // Array output and fwd registers both hold between reads, so the merged
    // word holds too. Until a read completes after reset the array register
    // is undefined, hence the zero gate.
    assign rd_dat_o = rd_seen_q
                    ? DAT_WD'(col_merge(MAX_COL_NUM'(fwd_col_q),
                                        MAX_DAT_WD'(fwd_dat_q),
                                        MAX_DAT_WD'(arr_rd_dat),
                                        COL_WD))
                    : '0;
    assign rd_val_o = rd_val_q;
    assign idle_o   = !wb_vld_q;

endmodule

// File: tb/tb_ram_sp_be_wbuf.sv
module tb_ram_sp_be_wbuf;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_ena_i;
    logic [9:0]  wr_adr_i;
    logic [3:0]  wr_col_i;
    logic [31:0] wr_dat_i;
    logic        wr_rdy_o;
    logic        rd_ena_i;
    logic [9:0]  rd_adr_i;
    logic        rd_val_o;
    logic [31:0] rd_dat_o;
    logic        idle_o;

    int n_cmp = 0;
    int n_bad = 0;
    int vld_cnt = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    ram_sp_be_wbuf #(.ADR_WD(10), .DAT_WD(32), .COL_WD(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_ena_i (wr_ena_i),
        .wr_adr_i (wr_adr_i),
        .wr_col_i (wr_col_i),
        .wr_dat_i (wr_dat_i),
        .wr_rdy_o (wr_rdy_o),
        .rd_ena_i (rd_ena_i),
        .rd_adr_i (rd_adr_i),
        .rd_val_o (rd_val_o),
        .rd_dat_o (rd_dat_o),
        .idle_o   (idle_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [9:0] ra,
                         input logic wr, input logic [9:0] wa,
                         input logic [3:0] col, input logic [31:0] wd);
        rd_ena_i = rd;
        rd_adr_i = ra;
        wr_ena_i = wr;
        wr_adr_i = wa;
        wr_col_i = col;
        wr_dat_i = wd;
    endtask

    task automatic idle_in;
        drive(1'b0, 10'd0, 1'b0, 10'd0, 4'h0, 32'h0);
    endtask

    // Issue a read and record its expected data.
    task automatic rd_push(input logic [9:0] ra, input logic [31:0] exp, input string nm);
        drive(1'b1, ra, 1'b0, 10'd0, 4'h0, 32'h0);
        exp_q.push_back(exp);
        tag_q.push_back(nm);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rd_val_o pops one expectation.
    always @(negedge clk) begin
        if (rd_val_o === 1'b1) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rd_val: got data %h, expected no valid", rd_dat_o);
            end else begin
                chk(tag_q.pop_front(), rd_dat_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vld_before;
        rstn = 1'b0;
        idle_in();

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_val", {31'd0, rd_val_o}, 32'd0);
        chk("rst_rd_dat", rd_dat_o, 32'd0);
        chk("rst_idle",   {31'd0, idle_o},   32'd1);
        chk("rst_wr_rdy", {31'd0, wr_rdy_o}, 32'd1);
        rstn = 1'b1;
        step();

        // Direct write then read
        drive(1'b0, 10'd0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("direct_wr_rdy", {31'd0, wr_rdy_o}, 32'd1);
        step();
        chk("direct_idle", {31'd0, idle_o}, 32'd1);
        rd_push(10'd5, 32'hDEADBEEF, "direct_rd5");
        step();
        idle_in();
        chk("direct_idle_after", {31'd0, idle_o}, 32'd1);
        step();

        // Concurrent read + write to the same address, then forwarding
        drive(1'b0, 10'd0, 1'b1, 10'd7, 4'hF, 32'h11223344);
        step();
        rd_push(10'd7, 32'h11223344, "rbw_rd7");
        wr_ena_i = 1'b1;
        wr_adr_i = 10'd7;
        wr_col_i = 4'b0011;
        wr_dat_i = 32'hAABBCCDD;
        @(negedge clk);
        chk("conc_wr_rdy", {31'd0, wr_rdy_o}, 32'd1);
        step();
        chk("conc_idle", {31'd0, idle_o}, 32'd0);
        rd_push(10'd7, 32'h1122CCDD, "fwd_rd7");
        step();
        idle_in();
        chk("fwd_idle_still_full", {31'd0, idle_o}, 32'd0);
        step();
        chk("drain_idle", {31'd0, idle_o}, 32'd1);
        rd_push(10'd7, 32'h1122CCDD, "array_rd7");
        step();
        idle_in();
        step();

        // Stall and drain
        rd_push(10'd5, 32'hDEADBEEF, "stall_rd5_0");
        wr_ena_i = 1'b1;
        wr_adr_i = 10'd20;
        wr_col_i = 4'hF;
        wr_dat_i = 32'h01010101;
        step();
        for (int i = 0; i < 4; i++) begin
            rd_push(10'd5, 32'hDEADBEEF, "stall_rd5");
            wr_ena_i = 1'b1;
            wr_adr_i = 10'd21;
            wr_col_i = 4'hF;
            wr_dat_i = 32'h02020202;
            @(negedge clk);
            chk("stall_wr_rdy", {31'd0, wr_rdy_o}, 32'd0);
            step();
        end
        drive(1'b0, 10'd0, 1'b1, 10'd21, 4'hF, 32'h02020202);
        @(negedge clk);
        chk("unstall_wr_rdy", {31'd0, wr_rdy_o}, 32'd1);
        step();
        idle_in();
        chk("reload_idle", {31'd0, idle_o}, 32'd0);
        step();
        chk("reload_drained_idle", {31'd0, idle_o}, 32'd1);
        rd_push(10'd20, 32'h01010101, "drain_rd20");
        step();
        rd_push(10'd21, 32'h02020202, "drain_rd21");
        step();
        idle_in();
        step();

        // Hold across idle cycles and writes to the same address
        vld_before = vld_cnt;
        rd_push(10'd5, 32'hDEADBEEF, "hold_rd5");
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) drive(1'b0, 10'd0, 1'b1, 10'd5, 4'h0, 32'h00000000);
            else        drive(1'b0, 10'd0, 1'b1, 10'd5, 4'hF, 32'hCAFEF00D);
            @(negedge clk);
            if (i == 2 || i == 6 || i == 9) chk("hold_rd_dat", rd_dat_o, 32'hDEADBEEF);
            step();
        end
        idle_in();
        step();
        chk("hold_single_valid", 32'(vld_cnt - vld_before), 32'd1);
        rd_push(10'd5, 32'hCAFEF00D, "noop_wr_rd5");
        step();
        idle_in();
        step();

        // Reset mid-operation
        drive(1'b0, 10'd0, 1'b1, 10'd9, 4'hF, 32'h12345678);
        step();
        // Read issued here is deliberately not expected: reset drops its valid.
        drive(1'b1, 10'd5, 1'b1, 10'd9, 4'hF, 32'h55AA55AA);
        step();
        idle_in();
        chk("pre_rst_idle", {31'd0, idle_o}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_idle", {31'd0, idle_o}, 32'd1);
        chk("mid_rst_rd_val", {31'd0, rd_val_o}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        chk("post_rst_rd_dat", rd_dat_o, 32'd0);
        rd_push(10'd9, 32'h12345678, "post_rst_rd9");
        step();
        idle_in();
        repeat (3) step();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_rd_val: got %0d outstanding, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
